bram_arb_ctrl: RTL and testbench

- Two-requester arbiter and sequencer for the single-port 8K x 8 BRAM (13-bit address, 8-bit data, en/we port).
- Accepts independent read/write requests from ports A and B and grants them round-robin.
- Drives the BRAM enable, write-enable, address and data-in pins, then returns read data to the winning requester after the BRAM read latency.
- Sits between the datapath clients and the BRAM block-design wrapper.

---
 rtl/bram_arb_ctrl.sv | 137 +++++++++++++
 tb/tb_bram_arb_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arb_ctrl.sv
// Round-robin arbiter/sequencer letting ports A and B share one single-port BRAM.
// Every output is registered; read data comes back READ_LAT+1 cycles after the grant pulse.
module bram_arb_ctrl #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);

  // Handshake: a requester raises req with we/addr/wdata stable and holds them
  // until it sees its one-cycle gnt; only in the cycle after gnt may it drop req
  // or present a new transaction. rvalid is a one-cycle pulse qualifying rdata.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RDWAIT = 2'd2} state_t;

  state_t              state, state_n;
  logic [1:0]          cnt, cnt_n;
  logic                last_grant, last_grant_n;  // 0 = A, 1 = B; also owner of the read in flight
  logic                a_gnt_n, b_gnt_n, a_rvalid_n, b_rvalid_n;
  logic                bram_en_n, bram_we_n;
  logic [ADDR_W-1:0]   bram_addr_n;
  logic [DATA_W-1:0]   bram_din_n, a_rdata_n, b_rdata_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      last_grant <= 1'b1;
      a_gnt      <= 1'b0;
      b_gnt      <= 1'b0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      last_grant <= last_grant_n;
      a_gnt      <= a_gnt_n;
      b_gnt      <= b_gnt_n;
      a_rvalid   <= a_rvalid_n;
      b_rvalid   <= b_rvalid_n;
      a_rdata    <= a_rdata_n;
      b_rdata    <= b_rdata_n;
      bram_en    <= bram_en_n;
      bram_we    <= bram_we_n;
      bram_addr  <= bram_addr_n;
      bram_din   <= bram_din_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    last_grant_n = last_grant;
    a_gnt_n      = 1'b0;
    b_gnt_n      = 1'b0;
    a_rvalid_n   = 1'b0;
    b_rvalid_n   = 1'b0;
    a_rdata_n    = a_rdata;
    b_rdata_n    = b_rdata;
    bram_en_n    = 1'b0;
    bram_we_n    = 1'b0;
    bram_addr_n  = bram_addr;
    bram_din_n   = bram_din;
    case (state)
      IDLE: begin
        // On a tie A wins only if B had the previous grant.
        if (a_req && (!b_req || last_grant)) begin
          bram_en_n    = 1'b1;
          bram_we_n    = a_we;
          bram_addr_n  = a_addr;
          bram_din_n   = a_wdata;
          a_gnt_n      = 1'b1;
          last_grant_n = 1'b0;
          state_n      = ISSUE;
        end else if (b_req) begin
          bram_en_n    = 1'b1;
          bram_we_n    = b_we;
          bram_addr_n  = b_addr;
          bram_din_n   = b_wdata;
          b_gnt_n      = 1'b1;
          last_grant_n = 1'b1;
          state_n      = ISSUE;
        end
      end
      ISSUE: begin
        if (bram_we) begin
          state_n = IDLE;
        end else begin
          state_n = RDWAIT;
          cnt_n   = 2'(READ_LAT - 1);
        end
      end
      RDWAIT: begin
        if (cnt == 2'd0) begin
          if (last_grant) begin
            b_rdata_n  = bram_dout;
            b_rvalid_n = 1'b1;
          end else begin
            a_rdata_n  = bram_dout;
            a_rvalid_n = 1'b1;
          end
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bram_arb_ctrl.sv
// Bench for bram_arb_ctrl: randomized two-port traffic against a memory/arbitration
// reference model with a queue scoreboard, plus a directed check of a READ_LAT=2 build.
module tb_bram_arb_ctrl;
  localparam int AW  = 13;
  localparam int DW  = 8;
  localparam int LAT = 1;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT (READ_LAT = 1) ----------------
  logic          a_req, a_we, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_gnt, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din, bram_dout;

  bram_arb_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem1[bram_addr] <= bram_din;
      else         bram_dout <= mem1[bram_addr];
    end
  end

  // ---------------- second DUT (READ_LAT = 2) ----------------
  logic          a2_req, a2_we, a2_gnt, a2_rvalid;
  logic [AW-1:0] a2_addr;
  logic [DW-1:0] a2_wdata, a2_rdata;
  logic          b2_req, b2_we, b2_gnt, b2_rvalid;
  logic [AW-1:0] b2_addr;
  logic [DW-1:0] b2_wdata, b2_rdata;
  logic          bram2_en, bram2_we;
  logic [AW-1:0] bram2_addr;
  logic [DW-1:0] bram2_din, bram2_dout, bram2_pipe;

  bram_arb_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a2_req), .a_we(a2_we), .a_addr(a2_addr), .a_wdata(a2_wdata),
    .a_gnt(a2_gnt), .a_rvalid(a2_rvalid), .a_rdata(a2_rdata),
    .b_req(b2_req), .b_we(b2_we), .b_addr(b2_addr), .b_wdata(b2_wdata),
    .b_gnt(b2_gnt), .b_rvalid(b2_rvalid), .b_rdata(b2_rdata),
    .bram_en(bram2_en), .bram_we(bram2_we), .bram_addr(bram2_addr),
    .bram_din(bram2_din), .bram_dout(bram2_dout)
  );

  logic [DW-1:0] mem2 [0:(1<<AW)-1];
  always @(posedge clk) begin
    bram2_dout <= bram2_pipe;
    if (bram2_en) begin
      if (bram2_we) mem2[bram2_addr] <= bram2_din;
      else          bram2_pipe <= mem2[bram2_addr];
    end
  end

  int b2_rv_cnt = 0;
  always @(negedge clk) if (rst_n && b2_rvalid) b2_rv_cnt++;

  // ---------------- checking helpers ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  txn_t          pend   [2];
  bit            pend_v [2];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] exp_a_q[$], exp_b_q[$];
  int            due_a_q[$], due_b_q[$];
  int            cyc = 0, next_ok = 0, reads_granted = 0, rv_count = 0;
  bit            model_last = 1'b1;   // 1 = B had the last grant
  bit            prev_a = 1'b0, prev_b = 1'b0;
  logic [DW-1:0] hold_a = '0, hold_b = '0;

  always @(negedge clk) begin
    int   exp_win, act_win, p;
    txn_t t;
    if (!rst_n) begin
      reads_granted -= exp_a_q.size() + exp_b_q.size();
      exp_a_q.delete(); exp_b_q.delete();
      due_a_q.delete(); due_b_q.delete();
      model_last = 1'b1;
      prev_a = 1'b0; prev_b = 1'b0;
      next_ok = 0;
      hold_a = '0; hold_b = '0;
    end else begin
      cyc++;
      // The arbiter is free when cyc >= next_ok; it then must grant whoever requested.
      exp_win = 0;
      if (cyc >= next_ok) begin
        if (prev_a && prev_b) exp_win = model_last ? 1 : 2;
        else if (prev_a)      exp_win = 1;
        else if (prev_b)      exp_win = 2;
      end
      act_win = {30'd0, b_gnt, a_gnt};
      chk("grant_winner", act_win, exp_win);
      chk("bram_en", bram_en, exp_win != 0);
      if (act_win == 1 || act_win == 2) begin
        p = act_win - 1;
        if (!pend_v[p]) begin
          chk("gnt_without_request", 0, 1);
        end else begin
          t = pend[p];
          pend_v[p] = 1'b0;
          chk("bram_we", bram_we, t.we);
          chk("bram_addr", bram_addr, t.addr);
          chk("bram_din", bram_din, t.wdata);
          if (t.we) begin
            ref_mem[int'(t.addr)] = t.wdata;
            next_ok = cyc + 2;
          end else begin
            if (p == 0) begin exp_a_q.push_back(ref_mem[int'(t.addr)]); due_a_q.push_back(cyc + LAT + 1); end
            else        begin exp_b_q.push_back(ref_mem[int'(t.addr)]); due_b_q.push_back(cyc + LAT + 1); end
            reads_granted++;
            next_ok = cyc + LAT + 2;
          end
          model_last = p[0];
        end
      end
      if (a_rvalid) begin
        rv_count++;
        if (exp_a_q.size() == 0) chk("a_rvalid_unexpected", 1, 0);
        else begin
          hold_a = exp_a_q.pop_front();
          chk("a_rvalid_latency", cyc, due_a_q.pop_front());
        end
      end
      if (b_rvalid) begin
        rv_count++;
        if (exp_b_q.size() == 0) chk("b_rvalid_unexpected", 1, 0);
        else begin
          hold_b = exp_b_q.pop_front();
          chk("b_rvalid_latency", cyc, due_b_q.pop_front());
        end
      end
      chk("a_rdata", a_rdata, hold_a);
      chk("b_rdata", b_rdata, hold_b);
      prev_a = a_req;
      prev_b = b_req;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 of the cycle after gnt.
  task automatic drive(input bit p, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bit seen = 1'b0;
    pend[p]   = '{we: we, addr: addr, wdata: wd};
    pend_v[p] = 1'b1;
    if (!p) begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1; end
    else    begin b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1; end
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if ((p ? b_gnt : a_gnt) === 1'b1) begin seen = 1'b1; break; end
    end
    chk(p ? "b_gnt_wait" : "a_gnt_wait", seen, 1);
    @(posedge clk); #1;
    if (!p) a_req = 1'b0; else b_req = 1'b0;
  endtask

  function automatic logic [AW-1:0] pool_addr(input int i);
    if (i == 0) return '0;
    if (i == 1) return {AW{1'b1}};
    return AW'(16 + i);
  endfunction

  task automatic rand_port(input bit p, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      drive(p, 1'($urandom_range(0, 1)), pool_addr($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit            seen;
    int            g, r;
    logic [DW-1:0] rd;
    rst_n = 1'b0;
    {a_req, a_we, a_addr, a_wdata} = '0;
    {b_req, b_we, b_addr, b_wdata} = '0;
    {a2_req, a2_we, a2_addr, a2_wdata} = '0;
    {b2_req, b2_we, b2_addr, b2_wdata} = '0;
    @(posedge clk); #1;
    chk("reset_outputs", {a_gnt, b_gnt, a_rvalid, b_rvalid, bram_en, bram_we}, 0);
    chk("reset_bus", {bram_addr, bram_din, a_rdata, b_rdata}, 0);
    chk("reset_outputs_lat2", {a2_gnt, b2_gnt, a2_rvalid, b2_rvalid, bram2_en, bram2_we}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single write then read-back from A.
    drive(0, 1'b1, 13'h0001, 8'h02);
    drive(0, 1'b0, 13'h0001, 8'h00);
    repeat (3) begin @(posedge clk); #1; end

    // Simultaneous writes, then read-backs.
    fork
      drive(0, 1'b1, 13'h0005, 8'h11);
      drive(1, 1'b1, 13'h0006, 8'h22);
    join
    fork
      drive(0, 1'b0, 13'h0006, 8'h00);
      drive(1, 1'b0, 13'h0005, 8'h00);
    join

    // Back-to-back reads from both ports.
    fork
      for (int i = 0; i < 4; i++) drive(0, 1'b0, (i % 2 == 0) ? 13'h0005 : 13'h0001, 8'h00);
      for (int i = 0; i < 4; i++) drive(1, 1'b0, (i % 2 == 0) ? 13'h0006 : 13'h0005, 8'h00);
    join

    // Fill the random address pool, then random mixed traffic.
    for (int i = 0; i < 16; i++) drive(i[0], 1'b1, pool_addr(i), 8'(i * 7 + 3));
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    repeat (4) begin @(posedge clk); #1; end

    // Reset while a B read is waiting for data.
    drive(1, 1'b0, 13'h0006, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("abort_bram_en", bram_en, 0);
    chk("abort_gnt", {a_gnt, b_gnt}, 0);
    chk("abort_rvalid", {a_rvalid, b_rvalid}, 0);
    chk("abort_bram_addr", bram_addr, 0);
    chk("abort_rdata", {a_rdata, b_rdata}, 0);
    @(posedge clk); #1;
    fork
      begin repeat (3) begin @(posedge clk); #1; end rst_n = 1'b1; end
      drive(0, 1'b0, 13'h0005, 8'h00);
      drive(1, 1'b0, 13'h0006, 8'h00);
    join

    // Drain outstanding responses.
    for (int k = 0; k < 200; k++) begin
      if (exp_a_q.size() + exp_b_q.size() == 0 && !pend_v[0] && !pend_v[1]) break;
      @(posedge clk); #1;
    end
    repeat (2) begin @(posedge clk); #1; end
    chk("drain_outstanding", exp_a_q.size() + exp_b_q.size() + int'(pend_v[0]) + int'(pend_v[1]), 0);
    chk("rvalid_count", rv_count, reads_granted);

    // READ_LAT = 2 build: B writes 0x22 to 0x0006, A reads it back.
    b2_we = 1'b1; b2_addr = 13'h0006; b2_wdata = 8'h22; b2_req = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (b2_gnt) begin seen = 1'b1; break; end
    end
    chk("lat2_write_gnt", seen, 1);
    @(posedge clk); #1;
    b2_req = 1'b0;
    a2_we = 1'b0; a2_addr = 13'h0006; a2_req = 1'b1;
    g = -1; r = -1; rd = '0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (a2_gnt) g = k;
      if (g >= 0 && k == g + 1) a2_req = 1'b0;
      if (a2_rvalid) begin r = k; rd = a2_rdata; break; end
    end
    a2_req = 1'b0;
    chk("lat2_read_gnt", g >= 0, 1);
    chk("lat2_rvalid_latency", r - g, 3);
    chk("lat2_rdata", rd, 8'h22);
    repeat (4) begin @(posedge clk); #1; end
    chk("lat2_b_rvalid_count", b2_rv_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
